data_cache_control: RTL and testbench

Control FSM for the L1 data cache. Sits directly upstream of `data_cache_execute`. It sequences CPU requests through lookup, dirty-victim writeback and line fill, and drives every mux select and array load strobe of that datapath. It also owns the physical-memory handshake toward the arbiter / L2.

---
 rtl/data_cache_control_if.sv | 46 ++++
 rtl/data_cache_control.sv | 132 +++++++++++++
 tb/tb_data_cache_control.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_control_if.sv
// Select encodings shared with data_cache_execute, and the control <-> datapath/pmem
// signal bundle. master = data_cache_control, slave = CPU/datapath/pmem side.
package dcache_pkg;
    typedef enum logic {WAYMUX_WAYHIT, WAYMUX_WAYLRU} dcache_waymux_sel_t;
    typedef enum logic {RESPMUX_WAYMUX_OUT, RESPMUX_PMEM_READ} dcache_respmux_sel_t;
    typedef enum logic {MAMUX_CPU, MAMUX_WAYLRU} dcache_mamux_sel_t;
    typedef enum logic [1:0] {WDATA_FROM_CPU, WDATA_FROM_MEM, WDATA_MEM_MASK_CPU} dcache_wdata_mux_sel_t;
    typedef enum logic {WREN_AS_HIT, WREN_AS_LRU} dcache_wren_mux_sel_t;
    typedef enum logic [1:0] {HITMUX_FORCE_ZERO, HITMUX_AS_HIT, HITMUX_FORCE_ONE} dcache_hitmux_sel_t;
    typedef enum logic {DIRTY_WREN_WAY_HIT, DIRTY_WREN_WAY_LRU} dcache_dirty_wren_mux_sel_t;
    typedef enum logic {LRU_INV_HIT, LRU_INV_LRU} dcache_lru_wdata_mux_sel_t;
endpackage

interface data_cache_control_if;
    import dcache_pkg::*;

    logic mem_read, mem_write, mem_resp;
    logic hit, read_dirty;
    logic pmem_resp, pmem_read, pmem_write;
    logic load_request, load_tag, load_valid, load_data, load_dirty, load_lru;
    logic dirty_wdata;
    dcache_waymux_sel_t         waymux_sel;
    dcache_respmux_sel_t        respmux_sel;
    dcache_mamux_sel_t          mamux_sel;
    dcache_wdata_mux_sel_t      wdata_mux_sel;
    dcache_wren_mux_sel_t       wren_mux_sel;
    dcache_hitmux_sel_t         hitmux_sel;
    dcache_dirty_wren_mux_sel_t dirty_wren_mux_sel;
    dcache_lru_wdata_mux_sel_t  lru_wdata_mux_sel;

    modport master (
        input  mem_read, mem_write, hit, read_dirty, pmem_resp,
        output mem_resp, pmem_read, pmem_write,
        output load_request, load_tag, load_valid, load_data, load_dirty, load_lru, dirty_wdata,
        output waymux_sel, respmux_sel, mamux_sel, wdata_mux_sel, wren_mux_sel,
        output hitmux_sel, dirty_wren_mux_sel, lru_wdata_mux_sel
    );

    modport slave (
        output mem_read, mem_write, hit, read_dirty, pmem_resp,
        input  mem_resp, pmem_read, pmem_write,
        input  load_request, load_tag, load_valid, load_data, load_dirty, load_lru, dirty_wdata,
        input  waymux_sel, respmux_sel, mamux_sel, wdata_mux_sel, wren_mux_sel,
        input  hitmux_sel, dirty_wren_mux_sel, lru_wdata_mux_sel
    );
endinterface

// File: rtl/data_cache_control.sv
// L1 data cache control FSM: lookup, dirty-victim writeback, line fill, pmem handshake.
// Optional DCACHE_FILL_FORWARD_EN answers the CPU straight from the fill response.
module data_cache_control
    import dcache_pkg::*;
#(
    parameter int WAIT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    data_cache_control_if.master  bus,
    output logic                  busy_o,
    output logic [WAIT_BITS-1:0]  pmem_wait_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_FILL} state_t;

    state_t               state_q, state_d;
    logic [WAIT_BITS-1:0] wait_q, wait_d;
    logic                 in_pmem_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through this block can infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (bus.mem_read || bus.mem_write) state_d = S_LOOKUP;
            S_LOOKUP:    if (bus.hit)                       state_d = S_IDLE;
                         else if (bus.read_dirty)           state_d = S_WRITEBACK;
                         else                               state_d = S_FILL;
            S_WRITEBACK: if (bus.pmem_resp)                 state_d = S_FILL;
            S_FILL: begin
                if (bus.pmem_resp) begin
`ifdef DCACHE_FILL_FORWARD_EN
                    state_d = S_IDLE;
`else
                    state_d = S_LOOKUP;
`endif
                end
            end
            default:                                        state_d = S_IDLE;
        endcase
    end

    assign in_pmem_q = (state_q == S_WRITEBACK) || (state_q == S_FILL);

    // Cleared on each pmem entry (including WRITEBACK -> FILL), saturating while waiting.
    always_comb begin
        wait_d = wait_q;
        if ((state_d == S_WRITEBACK || state_d == S_FILL) && state_d != state_q)
            wait_d = '0;
        else if (in_pmem_q && !bus.pmem_resp && wait_q != '1)
            wait_d = wait_q + 1'b1;
    end

    always_comb begin
        bus.mem_resp           = 1'b0;
        bus.pmem_read          = 1'b0;
        bus.pmem_write         = 1'b0;
        bus.load_request       = 1'b0;
        bus.load_tag           = 1'b0;
        bus.load_valid         = 1'b0;
        bus.load_data          = 1'b0;
        bus.load_dirty         = 1'b0;
        bus.load_lru           = 1'b0;
        bus.dirty_wdata        = 1'b0;
        bus.hitmux_sel         = HITMUX_FORCE_ZERO;
        bus.mamux_sel          = MAMUX_CPU;
        bus.waymux_sel         = WAYMUX_WAYHIT;
        bus.respmux_sel        = RESPMUX_WAYMUX_OUT;
        bus.wdata_mux_sel      = WDATA_FROM_CPU;
        bus.wren_mux_sel       = WREN_AS_HIT;
        bus.dirty_wren_mux_sel = DIRTY_WREN_WAY_HIT;
        bus.lru_wdata_mux_sel  = LRU_INV_HIT;
        unique case (state_q)
            S_IDLE: bus.load_request = bus.mem_read | bus.mem_write;
            S_LOOKUP: begin
                bus.hitmux_sel = HITMUX_AS_HIT;
                if (bus.hit) begin
                    bus.mem_resp = 1'b1;
                    bus.load_lru = 1'b1;
                    if (bus.mem_write) begin
                        bus.load_data   = 1'b1;
                        bus.load_dirty  = 1'b1;
                        bus.dirty_wdata = 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                bus.pmem_write = 1'b1;
                bus.mamux_sel  = MAMUX_WAYLRU;
                bus.waymux_sel = WAYMUX_WAYLRU;
            end
            S_FILL: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    bus.load_data          = 1'b1;
                    bus.wren_mux_sel       = WREN_AS_LRU;
                    bus.load_tag           = 1'b1;
                    bus.load_valid         = 1'b1;
                    bus.load_dirty         = 1'b1;
                    bus.dirty_wren_mux_sel = DIRTY_WREN_WAY_LRU;
                    bus.load_lru           = 1'b1;
                    bus.lru_wdata_mux_sel  = LRU_INV_LRU;
`ifdef DCACHE_FILL_FORWARD_EN
                    bus.mem_resp      = 1'b1;
                    bus.hitmux_sel    = HITMUX_FORCE_ONE;
                    bus.respmux_sel   = RESPMUX_PMEM_READ;
                    bus.wdata_mux_sel = bus.mem_write ? WDATA_MEM_MASK_CPU : WDATA_FROM_MEM;
                    bus.dirty_wdata   = bus.mem_write;
`else
                    bus.wdata_mux_sel = WDATA_FROM_MEM;
`endif
                end
            end
            default: ;
        endcase
    end

    assign busy_o            = (state_q != S_IDLE);
    assign pmem_wait_count_o = wait_q;

endmodule

// File: tb/tb_data_cache_control.sv
// Self-checking bench for data_cache_control: each transaction is expanded into a
// per-cycle timeline of expected outputs, with randomized latencies and hit/dirty mix.
module tb_data_cache_control;
    import dcache_pkg::*;

    localparam int WAIT_BITS = 3;
    localparam int CNT_MAX   = (1 << WAIT_BITS) - 1;
`ifdef DCACHE_FILL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef enum {PH_IDLE, PH_REQ, PH_LOOKUP, PH_WB, PH_FILL} phase_t;

    typedef struct {
        phase_t ph;
        int     off;
        bit     resp;
        bit     hit;
        bit     req;
        bit     rst;
    } step_t;

    typedef struct packed {
        logic pmem_read, pmem_write, mem_resp, load_request;
        logic load_tag, load_valid, load_data, load_dirty, load_lru, dirty_wdata, busy;
        dcache_waymux_sel_t         waymux;
        dcache_respmux_sel_t        respmux;
        dcache_mamux_sel_t          mamux;
        dcache_wdata_mux_sel_t      wdata;
        dcache_wren_mux_sel_t       wren;
        dcache_hitmux_sel_t         hitmux;
        dcache_dirty_wren_mux_sel_t dirty_wren;
        dcache_lru_wdata_mux_sel_t  lru_wdata;
    } obs_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 busy;
    logic [WAIT_BITS-1:0] wait_count;
    int                   n_checks = 0;
    int                   n_fail   = 0;
    int                   exp_cnt  = 0;

    data_cache_control_if bus ();

    data_cache_control #(.WAIT_BITS(WAIT_BITS)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .busy_o            (busy),
        .pmem_wait_count_o (wait_count)
    );

    always #5 clk = ~clk;

    function automatic obs_t idle_obs();
        obs_t e;
        e = '0;
        e.waymux     = WAYMUX_WAYHIT;
        e.respmux    = RESPMUX_WAYMUX_OUT;
        e.mamux      = MAMUX_CPU;
        e.wdata      = WDATA_FROM_CPU;
        e.wren       = WREN_AS_HIT;
        e.hitmux     = HITMUX_FORCE_ZERO;
        e.dirty_wren = DIRTY_WREN_WAY_HIT;
        e.lru_wdata  = LRU_INV_HIT;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t g;
        g.pmem_read    = bus.pmem_read;
        g.pmem_write   = bus.pmem_write;
        g.mem_resp     = bus.mem_resp;
        g.load_request = bus.load_request;
        g.load_tag     = bus.load_tag;
        g.load_valid   = bus.load_valid;
        g.load_data    = bus.load_data;
        g.load_dirty   = bus.load_dirty;
        g.load_lru     = bus.load_lru;
        g.dirty_wdata  = bus.dirty_wdata;
        g.busy         = busy;
        g.waymux       = bus.waymux_sel;
        g.respmux      = bus.respmux_sel;
        g.mamux        = bus.mamux_sel;
        g.wdata        = bus.wdata_mux_sel;
        g.wren         = bus.wren_mux_sel;
        g.hitmux       = bus.hitmux_sel;
        g.dirty_wren   = bus.dirty_wren_mux_sel;
        g.lru_wdata    = bus.lru_wdata_mux_sel;
        return g;
    endfunction

    // What the datapath and pmem side should see in a cycle of the given phase.
    function automatic obs_t expect_obs(step_t s, bit is_write);
        obs_t e;
        e = idle_obs();
        case (s.ph)
            PH_REQ: e.load_request = 1'b1;
            PH_LOOKUP: begin
                e.busy   = 1'b1;
                e.hitmux = HITMUX_AS_HIT;
                if (s.hit) begin
                    e.mem_resp = 1'b1;
                    e.load_lru = 1'b1;
                    if (is_write) begin
                        e.load_data   = 1'b1;
                        e.load_dirty  = 1'b1;
                        e.dirty_wdata = 1'b1;
                    end
                end
            end
            PH_WB: begin
                e.busy       = 1'b1;
                e.pmem_write = 1'b1;
                e.mamux      = MAMUX_WAYLRU;
                e.waymux     = WAYMUX_WAYLRU;
            end
            PH_FILL: begin
                e.busy      = 1'b1;
                e.pmem_read = 1'b1;
                if (s.resp) begin
                    e.load_data  = 1'b1;
                    e.wren       = WREN_AS_LRU;
                    e.wdata      = WDATA_FROM_MEM;
                    e.load_tag   = 1'b1;
                    e.load_valid = 1'b1;
                    e.load_dirty = 1'b1;
                    e.dirty_wren = DIRTY_WREN_WAY_LRU;
                    e.load_lru   = 1'b1;
                    e.lru_wdata  = LRU_INV_LRU;
                    if (FWD) begin
                        e.mem_resp = 1'b1;
                        e.hitmux   = HITMUX_FORCE_ONE;
                        e.respmux  = RESPMUX_PMEM_READ;
                        if (is_write) begin
                            e.wdata       = WDATA_MEM_MASK_CPU;
                            e.dirty_wdata = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic step_t mk(phase_t ph, int off, bit resp, bit hit, bit req, bit rs);
        step_t s;
        s.ph = ph; s.off = off; s.resp = resp; s.hit = hit; s.req = req; s.rst = rs;
        return s;
    endfunction

    task automatic drive_step(input step_t s, input bit is_write, input bit dirty,
                              input string name, input int idx);
        obs_t exp_o, got;
        @(posedge clk);
        #1;
        rst            = s.rst;
        bus.mem_read   = s.req && !is_write;
        bus.mem_write  = s.req && is_write;
        bus.hit        = s.hit;
        bus.read_dirty = dirty;
        bus.pmem_resp  = s.resp;
        @(negedge clk);
        if (s.rst)
            exp_cnt = 0;
        else if (s.ph == PH_WB || s.ph == PH_FILL)
            exp_cnt = (s.off > CNT_MAX) ? CNT_MAX : s.off;
        exp_o = s.rst ? idle_obs() : expect_obs(s, is_write);
        got   = sample();
        n_checks++;
        if (got !== exp_o) begin
            n_fail++;
            $display("FAIL %s step %0d outputs: got %h, expected %h", name, idx, got, exp_o);
        end
        n_checks++;
        if (wait_count !== WAIT_BITS'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s step %0d pmem_wait_count: got %0d, expected %0d",
                     name, idx, wait_count, exp_cnt);
        end
    endtask

    // One CPU request from the idle request cycle to mem_resp, plus an optional idle gap.
    task automatic run_txn(input bit is_write, input bit want_hit, input bit dirty,
                           input int wb_lat, input int fill_lat, input bit noise,
                           input bit gap, input string name);
        step_t q[$];
        bit    nr, nh;
        nr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        q.push_back(mk(PH_REQ, 0, nr, nr, 1'b1, 1'b0));
        nr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        q.push_back(mk(PH_LOOKUP, 0, nr, want_hit, 1'b1, 1'b0));
        if (!want_hit) begin
            if (dirty)
                for (int k = 0; k <= wb_lat; k++) begin
                    nh = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    q.push_back(mk(PH_WB, k, k == wb_lat, nh, 1'b1, 1'b0));
                end
            for (int k = 0; k <= fill_lat; k++) begin
                nh = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                q.push_back(mk(PH_FILL, k, k == fill_lat, nh, 1'b1, 1'b0));
            end
            if (!FWD) begin
                nr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                q.push_back(mk(PH_LOOKUP, 0, nr, 1'b1, 1'b1, 1'b0));
            end
        end
        if (gap) begin
            nr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            q.push_back(mk(PH_IDLE, 0, nr, 1'b0, 1'b0, 1'b0));
        end
        foreach (q[i]) drive_step(q[i], is_write, dirty, name, i);
    endtask

    task automatic test_reset();
        drive_step(mk(PH_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, "reset", 0);
        drive_step(mk(PH_IDLE, 0, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b1, "reset", 1);
        drive_step(mk(PH_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, "reset", 2);
    endtask

    task automatic test_read_hit();
        run_txn(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, "read_hit");
    endtask

    task automatic test_write_hit();
        run_txn(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, "write_hit");
    endtask

    task automatic test_clean_miss();
        run_txn(1'b0, 1'b0, 1'b0, 0, 5, 1'b0, 1'b1, "clean_read_miss");
    endtask

    task automatic test_dirty_miss();
        run_txn(1'b1, 1'b0, 1'b1, 3, 2, 1'b0, 1'b1, "dirty_write_miss");
    endtask

    task automatic test_boundaries();
        run_txn(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, "same_cycle_resp");
        run_txn(1'b1, 1'b0, 1'b0, 0, 11, 1'b0, 1'b1, "wait_saturation");
    endtask

    task automatic test_reset_mid_fill();
        step_t q[$];
        q.push_back(mk(PH_REQ, 0, 1'b0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(PH_LOOKUP, 0, 1'b0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(PH_FILL, 0, 1'b0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(PH_FILL, 1, 1'b0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(PH_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b1));
        q.push_back(mk(PH_IDLE, 0, 1'b1, 1'b0, 1'b0, 1'b1));
        q.push_back(mk(PH_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (q[i]) drive_step(q[i], 1'b0, 1'b0, "reset_mid_fill", i);
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++)
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 10)), 1'b1,
                    1'($urandom_range(0, 1)), "random");
        drive_step(mk(PH_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, "random_tail", 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.hit        = 1'b0;
        bus.read_dirty = 1'b0;
        bus.pmem_resp  = 1'b0;
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_miss();
        test_boundaries();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
